// File: rtl/wall_collision_if.sv
// Signal bundle between wall_collision, the sprite position source and the maze tile ROM.
// The slave modport is the collision block's view; master is the environment's view.
interface wall_collision_if;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  mapa_x;
  logic [2:0]  mapa_y;
  logic [14:0] tile_addr;
  logic        tile_data;
  logic        collision;
  logic        done;

  modport master (
    output x_pos, y_pos, mapa_x, mapa_y, tile_data,
    input  tile_addr, collision, done
  );

  modport slave (
    input  x_pos, y_pos, mapa_x, mapa_y, tile_data,
    output tile_addr, collision, done
  );
endinterface

// File: rtl/wall_collision.sv
// Six-cycle evaluation loop: snapshot the sprite position, probe the tile ROM at the four
// sprite corners and publish a registered wall-collision flag with a one-cycle done pulse.
module wall_collision #(
  parameter int SPRITE_SIZE = 16,
  parameter int TILE_SHIFT  = 5,
  parameter int H_OFFSET    = 144,
  parameter int V_OFFSET    = 35
) (
  input  logic            CLOCK_25,
  input  logic            reset,
  wall_collision_if.slave bus
);

  typedef enum logic [2:0] {
    LATCH = 3'd0,
    C0    = 3'd1,
    C1    = 3'd2,
    C2    = 3'd3,
    C3    = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic signed [10:0] L_H_OFF   = 11'(H_OFFSET);
  localparam logic signed [10:0] L_V_OFF   = 11'(V_OFFSET);
  localparam logic signed [10:0] L_EDGE    = 11'(SPRITE_SIZE - 1);
  localparam logic signed [10:0] L_COL_END = 11'sd640;
  localparam logic signed [10:0] L_ROW_END = 11'sd480;

  state_t             r_state;
  state_t             w_next_state;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic [2:0]         r_mx;
  logic [2:0]         r_my;
  logic               r_hit;
  logic               r_inb;
  logic               r_inb_d;
  logic [14:0]        r_tile_addr;
  logic               r_collision;
  logic               r_done;

  logic               w_load;
  logic               w_sample;
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic [9:0]         w_src_x;
  logic [9:0]         w_src_y;
  logic [2:0]         w_src_mx;
  logic [2:0]         w_src_my;
  logic signed [10:0] w_col;
  logic signed [10:0] w_row;
  logic [4:0]         w_tile_col;
  logic [3:0]         w_tile_row;
  logic               w_inb;
  logic [14:0]        w_addr;
  logic               w_tile_bit;

  // The address register is loaded on entry to C0..C3, so each state selects the corner of the next one.
  always_comb begin
    w_next_state = LATCH;
    w_load       = 1'b0;
    w_sample     = 1'b0;
    w_dx         = 11'sd0;
    w_dy         = 11'sd0;
    case (r_state)
      LATCH: begin
        w_next_state = C0;
        w_load       = 1'b1;
      end
      C0: begin
        w_next_state = C1;
        w_load       = 1'b1;
        w_dx         = L_EDGE;
      end
      C1: begin
        w_next_state = C2;
        w_load       = 1'b1;
        w_sample     = 1'b1;
        w_dy         = L_EDGE;
      end
      C2: begin
        w_next_state = C3;
        w_load       = 1'b1;
        w_sample     = 1'b1;
        w_dx         = L_EDGE;
        w_dy         = L_EDGE;
      end
      C3: begin
        w_next_state = FIN;
        w_sample     = 1'b1;
      end
      FIN: begin
        w_next_state = LATCH;
        w_sample     = 1'b1;
      end
      default: begin
        w_next_state = LATCH;
      end
    endcase
  end

  // The top-left address leaves LATCH in the same edge as the snapshot, so it uses the live inputs.
  assign w_src_x  = (r_state == LATCH) ? bus.x_pos  : r_x;
  assign w_src_y  = (r_state == LATCH) ? bus.y_pos  : r_y;
  assign w_src_mx = (r_state == LATCH) ? bus.mapa_x : r_mx;
  assign w_src_my = (r_state == LATCH) ? bus.mapa_y : r_my;

  assign w_col = $signed({1'b0, w_src_x}) - L_H_OFF + w_dx;
  assign w_row = $signed({1'b0, w_src_y}) - L_V_OFF + w_dy;

  assign w_inb = !w_col[10] && (w_col < L_COL_END) && !w_row[10] && (w_row < L_ROW_END);

  assign w_tile_col = w_col[TILE_SHIFT +: 5];
  assign w_tile_row = w_row[TILE_SHIFT +: 4];
  assign w_addr     = w_inb ? {w_src_my, w_src_mx, w_tile_row, w_tile_col} : 15'd0;

  // ROM data belongs to the corner driven one state earlier, whose bounds flag is r_inb_d.
  assign w_tile_bit = bus.tile_data & r_inb_d;

  // FSM state register.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_state <= LATCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Position and room snapshot taken once per evaluation.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_x  <= 10'd0;
      r_y  <= 10'd0;
      r_mx <= 3'd0;
      r_my <= 3'd0;
    end else if (r_state == LATCH) begin
      r_x  <= bus.x_pos;
      r_y  <= bus.y_pos;
      r_mx <= bus.mapa_x;
      r_my <= bus.mapa_y;
    end else begin
      r_x  <= r_x;
      r_y  <= r_y;
      r_mx <= r_mx;
      r_my <= r_my;
    end
  end

  // ROM address and the bounds flags that travel with it.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_tile_addr <= 15'd0;
      r_inb       <= 1'b0;
      r_inb_d     <= 1'b0;
    end else begin
      r_inb_d <= r_inb;
      if (w_load) begin
        r_tile_addr <= w_addr;
        r_inb       <= w_inb;
      end else begin
        r_tile_addr <= r_tile_addr;
        r_inb       <= r_inb;
      end
    end
  end

  // Wall accumulator across the four corner samples.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_hit <= 1'b0;
    end else if (r_state == LATCH) begin
      r_hit <= 1'b0;
    end else if (w_sample) begin
      r_hit <= r_hit | w_tile_bit;
    end else begin
      r_hit <= r_hit;
    end
  end

  // Published result and completion pulse.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_collision <= 1'b0;
      r_done      <= 1'b0;
    end else if (r_state == FIN) begin
      r_collision <= r_hit | w_tile_bit;
      r_done      <= 1'b1;
    end else begin
      r_collision <= r_collision;
      r_done      <= 1'b0;
    end
  end

  assign bus.tile_addr = r_tile_addr;
  assign bus.collision = r_collision;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_wall_collision.sv
// Self-checking bench for wall_collision: hand-written corner sequences, a vector table
// and randomized positions against a corner-by-corner arithmetic reference.
module tb_wall_collision;
  localparam int SPRITE_SIZE = 16;
  localparam int TILE_SHIFT  = 5;
  localparam int H_OFFSET    = 144;
  localparam int V_OFFSET    = 35;
  localparam int TILE        = 1 << TILE_SHIFT;

  logic CLOCK_25 = 1'b0;
  logic reset;
  wall_collision_if bus();

  wall_collision #(
    .SPRITE_SIZE(SPRITE_SIZE),
    .TILE_SHIFT (TILE_SHIFT),
    .H_OFFSET   (H_OFFSET),
    .V_OFFSET   (V_OFFSET)
  ) dut (
    .CLOCK_25(CLOCK_25),
    .reset   (reset),
    .bus     (bus)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  bit rom [0:32767];
  int cur_mode = -1;
  int n_tests  = 0;
  int n_fail   = 0;

  // Synchronous tile ROM: data follows the address by one clock.
  always @(posedge CLOCK_25) bus.tile_data <= rom[bus.tile_addr];

  typedef struct {
    int x;
    int y;
    int mx;
    int my;
    int mode;
    int exp;
  } vec_t;

  vec_t vecs [16];

  function automatic int model(int x, int y, int mx, int my);
    int hit = 0;
    for (int k = 0; k < 4; k++) begin
      int col;
      int row;
      col = x - H_OFFSET + (((k % 2) == 1) ? SPRITE_SIZE - 1 : 0);
      row = y - V_OFFSET + ((k >= 2) ? SPRITE_SIZE - 1 : 0);
      if (col >= 0 && col < 640 && row >= 0 && row < 480) begin
        if (rom[my * 4096 + mx * 512 + (row / TILE) * 32 + col / TILE]) hit = 1;
      end
    end
    return hit;
  endfunction

  // 0 empty, 1 all walls, 2 single wall at 4842, 3 walls except tile column 0,
  // 4 walls only in tile rows >= 15, 5 random
  task automatic fill_rom(int mode);
    if (mode != cur_mode || mode == 5) begin
      for (int a = 0; a < 32768; a++) begin
        case (mode)
          0: rom[a] = 1'b0;
          1: rom[a] = 1'b1;
          2: rom[a] = (a == 4842);
          3: rom[a] = (a[4:0] != 5'd0);
          4: rom[a] = (a[8:5] >= 4'd15);
          default: rom[a] = ($urandom_range(0, 6) == 0);
        endcase
      end
      cur_mode = mode;
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no done pulse within 20 cycles", name);
  endtask

  task automatic wait_done(string name);
    int k = 0;
    @(negedge CLOCK_25);
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge CLOCK_25);
      k++;
    end
    if (bus.done !== 1'b1) timeout(name);
  endtask

  task automatic count_to_done(output int k);
    k = 0;
    do begin
      @(negedge CLOCK_25);
      k++;
    end while (bus.done !== 1'b1 && k < 20);
  endtask

  task automatic apply(int x, int y, int mx, int my);
    bus.x_pos  = 10'(x);
    bus.y_pos  = 10'(y);
    bus.mapa_x = 3'(mx);
    bus.mapa_y = 3'(my);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    vecs[0]  = '{449, 259, 1, 1, 2, 1};
    vecs[1]  = '{444, 259, 1, 1, 2, 0};
    vecs[2]  = '{449, 259, 2, 1, 2, 0};
    vecs[3]  = '{130, 259, 0, 0, 1, 1};
    vecs[4]  = '{130, 259, 0, 0, 3, 0};
    vecs[5]  = '{449, 505, 0, 0, 1, 1};
    vecs[6]  = '{449, 505, 0, 0, 4, 0};
    vecs[7]  = '{144, 35, 3, 5, 1, 1};
    vecs[8]  = '{783, 35, 0, 0, 1, 1};
    vecs[9]  = '{784, 35, 0, 0, 1, 0};
    vecs[10] = '{144, 514, 0, 0, 1, 1};
    vecs[11] = '{144, 515, 0, 0, 1, 0};
    vecs[12] = '{129, 35, 0, 0, 1, 1};
    vecs[13] = '{128, 35, 0, 0, 1, 0};
    vecs[14] = '{144, 19, 0, 0, 1, 0};
    vecs[15] = '{1023, 1023, 7, 7, 1, 0};

    // Reset held with an all-wall ROM
    reset = 1'b1;
    fill_rom(1);
    apply(449, 259, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_25);
      check($sformatf("reset collision c%0d", i), int'(bus.collision), 0);
      check($sformatf("reset done c%0d", i), int'(bus.done), 0);
      check($sformatf("reset tile_addr c%0d", i), int'(bus.tile_addr), 0);
    end
    reset = 1'b0;
    count_to_done(k);
    check("first done latency", k, 6);
    check("first collision", int'(bus.collision), model(449, 259, 1, 1));

    // Steady six-cycle cadence
    for (int i = 0; i < 3; i++) begin
      count_to_done(k);
      check($sformatf("done period %0d", i), k, 6);
    end

    // Wall hit: addresses per corner state
    fill_rom(2);
    apply(449, 259, 1, 1);
    wait_done("hit pre1");
    wait_done("hit pre2");
    @(negedge CLOCK_25);
    check("C0 tile_addr", int'(bus.tile_addr), 4841);
    @(negedge CLOCK_25);
    check("C1 tile_addr", int'(bus.tile_addr), 4842);
    @(negedge CLOCK_25);
    check("C2 tile_addr", int'(bus.tile_addr), 4841);
    @(negedge CLOCK_25);
    check("C3 tile_addr", int'(bus.tile_addr), 4842);
    @(negedge CLOCK_25);
    check("FIN done low", int'(bus.done), 0);
    @(negedge CLOCK_25);
    check("hit done", int'(bus.done), 1);
    check("hit collision", int'(bus.collision), 1);

    // Snapshot: input change during C2 only affects the next evaluation
    @(negedge CLOCK_25);
    @(negedge CLOCK_25);
    @(negedge CLOCK_25);
    apply(444, 259, 1, 1);
    wait_done("snap cur");
    check("snapshot current", int'(bus.collision), 1);
    wait_done("snap next");
    check("snapshot next", int'(bus.collision), 0);

    // Reset mid-evaluation abandons it
    fill_rom(1);
    apply(144, 35, 0, 0);
    wait_done("midrst pre1");
    wait_done("midrst pre2");
    check("midrst pre collision", int'(bus.collision), 1);
    @(negedge CLOCK_25);
    @(negedge CLOCK_25);
    reset = 1'b1;
    @(negedge CLOCK_25);
    check("midrst collision", int'(bus.collision), 0);
    check("midrst tile_addr", int'(bus.tile_addr), 0);
    reset = 1'b0;
    count_to_done(k);
    check("midrst done latency", k, 6);
    check("midrst collision after", int'(bus.collision), 1);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      fill_rom(vecs[i].mode);
      apply(vecs[i].x, vecs[i].y, vecs[i].mx, vecs[i].my);
      wait_done($sformatf("vec%0d a", i));
      wait_done($sformatf("vec%0d b", i));
      check($sformatf("vec%0d collision", i), int'(bus.collision), vecs[i].exp);
    end

    // Randomized positions against the reference
    for (int i = 0; i < 150; i++) begin
      int x;
      int y;
      int mx;
      int my;
      if (i % 50 == 0) fill_rom(5);
      x  = int'($urandom_range(100, 820));
      y  = int'($urandom_range(10, 540));
      mx = int'($urandom_range(0, 7));
      my = int'($urandom_range(0, 7));
      apply(x, y, mx, my);
      wait_done($sformatf("rand%0d a", i));
      wait_done($sformatf("rand%0d b", i));
      check($sformatf("rand%0d x=%0d y=%0d m=%0d,%0d", i, x, y, mx, my),
            int'(bus.collision), model(x, y, mx, my));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
